// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one 32-bit ALU (AND/XOR/SUB/ADD/CMP/ORR with zero/lt/gt flags)
// between NREQ requesters using round-robin arbitration. Requests and
// responses both use valid/ready handshakes. Only one operation is in
// flight at a time, and the response is registered.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   req_valid / req_ready    per-requester request handshake (ready is one-hot or zero)
//   req_op1 / req_op2        operands, requester i at [32*i +: 32]
//   req_alu_op               opcode, requester i at [4*i +: 4]
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   index of the requester that owns the response
//   rsp_result               ALU result
//   rsp_zero/rsp_lt/rsp_gt   result == 0, op1 < op2 and op1 > op2 (both unsigned)
//   busy                     high whenever the FSM is not idle
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_op1,
    input  logic [NREQ*32-1:0]   req_op2,
    input  logic [NREQ*4-1:0]    req_alu_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_lt,
    output logic                 rsp_gt,
    output logic                 busy
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state, state_next;
    logic [IDW-1:0]  last;
    logic [IDW-1:0]  winner;
    logic            found;
    int unsigned     cand;

    logic [31:0]     lat_op1, lat_op2;
    logic [3:0]      lat_op;
    logic [IDW-1:0]  lat_id;
    logic [31:0]     alu_res;
    logic            take;

    // Round-robin scan: the search starts just after the last winner and wraps.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last) + k) % NREQ;
            if (!found && req_valid[cand]) begin
                winner = IDW'(cand);
                found  = 1'b1;
            end
        end
    end

    // Gating with rst_n keeps req_ready low while reset is held, even though
    // the FSM sits in IDLE.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && found && rst_n) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign take = (state == IDLE) && found;
    assign busy = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (lat_op)
            OP_AND:          alu_res = lat_op1 & lat_op2;
            OP_XOR:          alu_res = lat_op1 ^ lat_op2;
            OP_SUB, OP_CMP:  alu_res = lat_op1 - lat_op2;
            OP_ADD:          alu_res = lat_op1 + lat_op2;
            OP_ORR:          alu_res = lat_op1 | lat_op2;
            default:         alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last       <= IDW'(NREQ - 1);
            lat_op1    <= '0;
            lat_op2    <= '0;
            lat_op     <= '0;
            lat_id     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_lt     <= 1'b0;
            rsp_gt     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        lat_op1 <= req_op1[32*winner +: 32];
                        lat_op2 <= req_op2[32*winner +: 32];
                        lat_op  <= req_alu_op[4*winner +: 4];
                        lat_id  <= winner;
                        last    <= winner;
                    end
                end
                EXEC: begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= lat_id;
                    rsp_result <= alu_res;
                    rsp_zero   <= (alu_res == '0);
                    rsp_lt     <= (lat_op1 < lat_op2);
                    rsp_gt     <= (lat_op1 > lat_op2);
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter (NREQ=3 to exercise pointer wrap).
module tb_alu_share_arbiter;

    localparam int NREQ = 3;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_op1;
    logic [NREQ*32-1:0]  req_op2;
    logic [NREQ*4-1:0]   req_alu_op;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_result;
    logic                rsp_zero, rsp_lt, rsp_gt;
    logic                busy;

    logic [31:0] op1 [NREQ];
    logic [31:0] op2 [NREQ];
    logic [3:0]  aop [NREQ];

    int checks   = 0;
    int failures = 0;
    int model_last;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_alu_op (req_alu_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_lt     (rsp_lt),
        .rsp_gt     (rsp_gt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_op1[32*i +: 32]  = op1[i];
            req_op2[32*i +: 32]  = op2[i];
            req_alu_op[4*i +: 4] = aop[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU: returns {gt, lt, zero, result}.
    function automatic logic [34:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0:        r = a & b;
            4'd1:        r = a ^ b;
            4'd2, 4'd10: r = a - b;
            4'd4:        r = a + b;
            4'd12:       r = a | b;
            default:     r = 32'd0;
        endcase
        return {a > b, a < b, r == 32'd0, r};
    endfunction

    // First valid requester in circular order after the last winner; -1 if none.
    function automatic int exp_winner(input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (model_last + k) % NREQ;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full arbitration round. Checks grant, EXEC latency, response content,
    // stability under stall cycles, and response retirement.
    task automatic run_op(input logic [NREQ-1:0] mask, input int stall,
                          output int win, output logic [31:0] res, output logic [2:0] flg);
        logic [34:0] exp;
        req_valid = mask;
        rsp_ready = 1'b0;
        #1;
        win = exp_winner(mask);
        check("grant", 32'(req_ready), (win < 0) ? 32'd0 : (32'd1 << win));
        check("busy_idle", 32'(busy), 32'd0);
        exp = (win < 0) ? '0 : alu_ref(aop[win], op1[win], op2[win]);
        res = '0;
        flg = '0;
        tick();
        if (win >= 0) begin
            model_last = win;
            check("exec_busy", 32'(busy), 32'd1);
            check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) op1[i] = $urandom;
            #1;
            check("exec_ready", 32'(req_ready), 32'd0);
            tick();
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_id", 32'(rsp_id), 32'(win));
            check("rsp_result", rsp_result, exp[31:0]);
            check("rsp_flags", 32'({rsp_gt, rsp_lt, rsp_zero}), 32'(exp[34:32]));
            res = rsp_result;
            flg = {rsp_gt, rsp_lt, rsp_zero};
            for (int s = 0; s < stall; s++) begin
                req_valid = NREQ'($urandom);
                #1;
                check("stall_ready", 32'(req_ready), 32'd0);
                tick();
                check("stall_valid", 32'(rsp_valid), 32'd1);
                check("stall_result", rsp_result, exp[31:0]);
                check("stall_id", 32'(rsp_id), 32'(win));
            end
            rsp_ready = 1'b1;
            req_valid = '0;
            tick();
            rsp_ready = 1'b0;
            check("retire_valid", 32'(rsp_valid), 32'd0);
            check("retire_busy", 32'(busy), 32'd0);
            check("retire_hold", rsp_result, exp[31:0]);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flg;   // {gt, lt, zero}
    } vec_t;

    vec_t vt [12];

    initial begin
        int          win;
        logic [31:0] res;
        logic [2:0]  flg;
        int          rr_exp [4];

        vt[0]  = '{4'b0100, 32'd7,         32'd5,         32'd12,        3'b100};
        vt[1]  = '{4'b1010, 32'd9,         32'd9,         32'd0,         3'b001};
        vt[2]  = '{4'b0010, 32'd1,         32'd2,         32'hFFFF_FFFF, 3'b010};
        vt[3]  = '{4'b0111, 32'd3,         32'd1,         32'd0,         3'b101};
        vt[4]  = '{4'b0100, 32'd1,         32'd1,         32'd2,         3'b000};
        vt[5]  = '{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 3'b100};
        vt[6]  = '{4'b0001, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0,         3'b001};
        vt[7]  = '{4'b1100, 32'h1000_0000, 32'h0000_0001, 32'h1000_0001, 3'b100};
        vt[8]  = '{4'b0100, 32'hFFFF_FFFF, 32'd1,         32'd0,         3'b101};
        vt[9]  = '{4'b0010, 32'd0,         32'd1,         32'hFFFF_FFFF, 3'b010};
        vt[10] = '{4'b1010, 32'd5,         32'd9,         32'hFFFF_FFFC, 3'b010};
        vt[11] = '{4'b1111, 32'd0,         32'd0,         32'd0,         3'b001};

        for (int i = 0; i < NREQ; i++) begin
            op1[i] = '0;
            op2[i] = '0;
            aop[i] = '0;
        end
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_result", rsp_result, 32'd0);
        check("reset_flags", 32'({rsp_gt, rsp_lt, rsp_zero}), 32'd0);
        req_valid  = '0;
        rst_n      = 1'b1;
        model_last = NREQ - 1;

        // Directed vectors, rotating the single active requester.
        for (int i = 0; i < 12; i++) begin
            int r;
            r = i % NREQ;
            aop[r] = vt[i].op;
            op1[r] = vt[i].a;
            op2[r] = vt[i].b;
            run_op(NREQ'(1 << r), i % 3, win, res, flg);
            check("vec_winner", 32'(win), 32'(r));
            check("vec_result", res, vt[i].res);
            check("vec_flags", 32'(flg), 32'(vt[i].flg));
        end

        // Long back-pressure: 5 stall cycles while req1 keeps requesting.
        aop[0] = 4'b0100; op1[0] = 32'd100; op2[0] = 32'd23;
        aop[1] = 4'b0010; op1[1] = 32'd50;  op2[1] = 32'd8;
        req_valid = 3'b001;
        rsp_ready = 1'b0;
        tick();
        model_last = 0;
        repeat (6) begin
            req_valid = 3'b010;
            #1;
            check("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        check("bp_valid", 32'(rsp_valid), 32'd1);
        check("bp_result", rsp_result, 32'd123);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        run_op(3'b010, 0, win, res, flg);
        check("bp_pending_win", 32'(win), 32'd1);
        check("bp_pending_res", res, 32'd42);

        // Reset in the middle of RESP: response discarded immediately.
        req_valid = 3'b010;
        tick();
        tick();
        check("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        req_valid = 3'b011;
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_reset_valid", 32'(rsp_valid), 32'd0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        req_valid  = '0;
        rst_n      = 1'b1;
        model_last = NREQ - 1;
        repeat (3) begin
            tick();
            check("post_reset_quiet", 32'(rsp_valid), 32'd0);
        end

        // Round-robin fairness with req0 and req1 both held.
        rr_exp = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            run_op(3'b011, 0, win, res, flg);
            check("rr_order", 32'(win), 32'(rr_exp[i]));
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                aop[i] = 4'($urandom_range(0, 15));
                op1[i] = $urandom;
                op2[i] = ($urandom_range(0, 3) == 0) ? op1[i] : $urandom;
            end
            run_op(NREQ'($urandom_range(0, 7)), $urandom_range(0, 3), win, res, flg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
